// File: rtl/mod_updown_counter.sv
// mod_updown_counter: parametrised up/down counter with programmable modulus,
// wrap or saturate behaviour at the limits, synchronous load/clear and a
// registered one-cycle limit-event flag.
//
// The next value is formed at WIDTH+1 bits and checked against MAX_VALUE
// explicitly. This way a modulus smaller than 2**WIDTH wraps correctly and the
// stored count can never exceed MAX_VALUE.
module mod_updown_counter #(
    parameter int unsigned     WIDTH     = 8,
    parameter longint unsigned MAX_VALUE = (64'd1 << WIDTH) - 64'd1,
    parameter bit              SATURATE  = 1'b0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             up_down,
    output logic [WIDTH-1:0] counter_out,
    output logic             wrapped,
    output logic             at_max,
    output logic             at_min
);

    // Limit held one bit wider than the count so every comparison is lossless.
    localparam logic [WIDTH:0] MAX_EXT = MAX_VALUE[WIDTH:0];
    localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrapped_q;
    logic             wrapped_d;

    logic [WIDTH:0]   cnt_ext_s;
    logic [WIDTH:0]   load_ext_s;
    logic [WIDTH:0]   inc_s;
    logic [WIDTH:0]   dec_s;

    assign cnt_ext_s  = {1'b0, count_q};
    assign load_ext_s = {1'b0, load_value};
    assign inc_s      = cnt_ext_s + ONE_EXT;
    assign dec_s      = cnt_ext_s - ONE_EXT;

    // Next-state selection: clear, then load, then enable, otherwise hold.
    always_comb begin
        count_d   = count_q;
        wrapped_d = 1'b0;
        if (clear) begin
            count_d   = {WIDTH{1'b0}};
            wrapped_d = 1'b0;
        end else if (load) begin
            // Values above the modulus are clamped, never stored raw.
            if (load_ext_s > MAX_EXT) begin
                count_d = MAX_EXT[WIDTH-1:0];
            end else begin
                count_d = load_value;
            end
            wrapped_d = 1'b0;
        end else if (enable) begin
            if (up_down) begin
                // >= rather than == so a corrupted count above the limit recovers.
                if (cnt_ext_s >= MAX_EXT) begin
                    wrapped_d = 1'b1;
                    if (SATURATE) begin
                        count_d = MAX_EXT[WIDTH-1:0];
                    end else begin
                        count_d = {WIDTH{1'b0}};
                    end
                end else begin
                    count_d   = inc_s[WIDTH-1:0];
                    wrapped_d = 1'b0;
                end
            end else begin
                if (cnt_ext_s == {(WIDTH+1){1'b0}}) begin
                    wrapped_d = 1'b1;
                    if (SATURATE) begin
                        count_d = {WIDTH{1'b0}};
                    end else begin
                        count_d = MAX_EXT[WIDTH-1:0];
                    end
                end else if (cnt_ext_s > MAX_EXT) begin
                    // Out-of-range count: pull back inside the modulus.
                    count_d   = MAX_EXT[WIDTH-1:0];
                    wrapped_d = 1'b0;
                end else begin
                    count_d   = dec_s[WIDTH-1:0];
                    wrapped_d = 1'b0;
                end
            end
        end else begin
            count_d   = count_q;
            wrapped_d = 1'b0;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q   <= {WIDTH{1'b0}};
            wrapped_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign counter_out = count_q;
    assign wrapped     = wrapped_q;
    assign at_max      = (count_q == MAX_EXT[WIDTH-1:0]);
    assign at_min      = (count_q == {WIDTH{1'b0}});

endmodule
